// File: rtl/pc_predictor.sv
// Fetch program counter with an internal sequential adder and a
// direct-mapped branch target buffer of 2-bit saturating counters.
module pc_predictor #(
    parameter int unsigned XLEN = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned BTB_ENTRIES = 16,
    localparam int unsigned IDX_W = $clog2(BTB_ENTRIES)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            pc_write,
    input  logic            is_not_cache_stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            update_valid,
    input  logic [XLEN-1:0] update_pc,
    input  logic            update_taken,
    input  logic [XLEN-1:0] update_target,
    output logic [XLEN-1:0] current_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target
);

    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [1:0]             btb_ctr    [BTB_ENTRIES];
    logic [TAG_W-1:0]       btb_tag    [BTB_ENTRIES];
    logic [XLEN-1:0]        btb_target [BTB_ENTRIES];

    logic             advance;
    logic [IDX_W-1:0] look_idx;
    logic [TAG_W-1:0] look_tag;
    logic             look_hit;
    logic [XLEN-1:0]  pc_plus4;

    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             train;

    // Byte offset bits never select an entry.
    logic unused_lsb;
    assign unused_lsb = ^{current_pc[1:0], update_pc[1:0]};

    assign advance = is_not_cache_stall;
    assign train   = advance && update_valid;

    assign look_idx = current_pc[IDX_W+1:2];
    assign look_tag = current_pc[XLEN-1:IDX_W+2];
    assign look_hit = btb_valid[look_idx] && (btb_tag[look_idx] == look_tag);
    assign pc_plus4 = current_pc + XLEN'(4);

    assign pred_taken  = look_hit && btb_ctr[look_idx][1];
    assign pred_target = pred_taken ? btb_target[look_idx] : pc_plus4;

    assign upd_idx = update_pc[IDX_W+1:2];
    assign upd_tag = update_pc[XLEN-1:IDX_W+2];
    assign upd_hit = btb_valid[upd_idx] && (btb_tag[upd_idx] == upd_tag);

    // A flush from EX wins over the hazard stall but not the cache stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            current_pc <= RESET_PC;
        end else if (advance && redirect_valid) begin
            current_pc <= redirect_pc;
        end else if (advance && pc_write) begin
            current_pc <= pred_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            btb_valid <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                btb_ctr[i] <= 2'b01;
            end
        end else if (train) begin
            if (upd_hit) begin
                if (update_taken && btb_ctr[upd_idx] != 2'b11) begin
                    btb_ctr[upd_idx] <= btb_ctr[upd_idx] + 2'd1;
                end else if (!update_taken && btb_ctr[upd_idx] != 2'b00) begin
                    btb_ctr[upd_idx] <= btb_ctr[upd_idx] - 2'd1;
                end
            end else if (update_taken) begin
                btb_valid[upd_idx] <= 1'b1;
                btb_ctr[upd_idx]   <= 2'b10;
            end
        end
    end

    // Tags and targets need no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (!reset && train && update_taken) begin
            btb_target[upd_idx] <= update_target;
            if (!upd_hit) begin
                btb_tag[upd_idx] <= upd_tag;
            end
        end
    end

endmodule

// File: tb/tb_pc_predictor.sv
// Directed bench for pc_predictor: sequential fetch, stalls, redirects,
// BTB training, aliasing, read-before-write and reset of a trained BTB.
module tb_pc_predictor;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write;
    logic        is_not_cache_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        update_valid;
    logic [31:0] update_pc;
    logic        update_taken;
    logic [31:0] update_target;
    logic [31:0] current_pc;
    logic        pred_taken;
    logic [31:0] pred_target;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pc_predictor #(
        .XLEN(32),
        .RESET_PC(32'h0),
        .BTB_ENTRIES(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pc_write(pc_write),
        .is_not_cache_stall(is_not_cache_stall),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .update_valid(update_valid),
        .update_pc(update_pc),
        .update_taken(update_taken),
        .update_target(update_target),
        .current_pc(current_pc),
        .pred_taken(pred_taken),
        .pred_target(pred_target)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pc_write = 1'b1;
        is_not_cache_stall = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        update_valid = 1'b0;
        update_pc = '0;
        update_taken = 1'b0;
        update_target = '0;
        step();
        step();
        reset = 1'b0;
        #1;
        n_vec++;
        if (current_pc !== 32'h0) begin
            n_err++;
            $display("FAIL reset_pc got %h want %h", current_pc, 32'h0);
        end
        n_vec++;
        if (pred_taken !== 1'b0) begin
            n_err++;
            $display("FAIL reset_pred got %b want 0", pred_taken);
        end
        n_vec++;
        if (pred_target !== 32'h4) begin
            n_err++;
            $display("FAIL reset_tgt got %h want %h", pred_target, 32'h4);
        end
    endtask

    task automatic test_free_run();
        logic [31:0] exp;
        for (int i = 1; i <= 4; i++) begin
            step();
            exp = 32'(i * 4);
            n_vec++;
            if (current_pc !== exp || pred_taken !== 1'b0) begin
                n_err++;
                $display("FAIL free_run pc %h pt %b want %h pt 0",
                         current_pc, pred_taken, exp);
            end
        end
    endtask

    task automatic test_stall();
        pc_write = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                pc_write = 1'b1;
                is_not_cache_stall = 1'b0;
            end
            step();
            n_vec++;
            if (current_pc !== 32'h10) begin
                n_err++;
                $display("FAIL stall_hold[%0d] got %h want %h",
                         i, current_pc, 32'h10);
            end
        end
        is_not_cache_stall = 1'b1;
        step();
        n_vec++;
        if (current_pc !== 32'h14) begin
            n_err++;
            $display("FAIL stall_release got %h want %h", current_pc, 32'h14);
        end
    endtask

    task automatic test_train();
        update_valid = 1'b1;
        update_pc = 32'h20;
        update_taken = 1'b1;
        update_target = 32'h100;
        step();
        update_valid = 1'b0;
        step();
        step();
        n_vec++;
        if (current_pc !== 32'h20 || pred_taken !== 1'b1
            || pred_target !== 32'h100) begin
            n_err++;
            $display("FAIL train_hit pc %h pt %b tgt %h want 20 1 100",
                     current_pc, pred_taken, pred_target);
        end
        step();
        n_vec++;
        if (current_pc !== 32'h100) begin
            n_err++;
            $display("FAIL train_follow got %h want %h", current_pc, 32'h100);
        end
        // Park at 0x20 and walk the counter down, then back up.
        pc_write = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h20;
        step();
        redirect_valid = 1'b0;
        update_valid = 1'b1;
        update_taken = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++;
            if (pred_taken !== 1'b0 || pred_target !== 32'h24) begin
                n_err++;
                $display("FAIL train_nt[%0d] pt %b tgt %h want 0 24",
                         i, pred_taken, pred_target);
            end
        end
        update_taken = 1'b1;
        step();
        n_vec++;
        if (pred_taken !== 1'b0) begin
            n_err++;
            $display("FAIL train_sat_lo pt %b want 0", pred_taken);
        end
        step();
        update_valid = 1'b0;
        n_vec++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h100) begin
            n_err++;
            $display("FAIL train_retake pt %b tgt %h want 1 100",
                     pred_taken, pred_target);
        end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1;
        redirect_pc = 32'h40;
        step();
        redirect_pc = 32'h200;
        step();
        n_vec++;
        if (current_pc !== 32'h200) begin
            n_err++;
            $display("FAIL redir_flush got %h want %h", current_pc, 32'h200);
        end
        redirect_pc = 32'h40;
        step();
        redirect_pc = 32'h200;
        is_not_cache_stall = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++;
            if (current_pc !== 32'h40) begin
                n_err++;
                $display("FAIL redir_stall[%0d] got %h want %h",
                         i, current_pc, 32'h40);
            end
        end
        is_not_cache_stall = 1'b1;
        step();
        redirect_valid = 1'b0;
        n_vec++;
        if (current_pc !== 32'h200) begin
            n_err++;
            $display("FAIL redir_late got %h want %h", current_pc, 32'h200);
        end
    endtask

    task automatic test_alias();
        redirect_valid = 1'b1;
        redirect_pc = 32'h60;
        step();
        redirect_valid = 1'b0;
        n_vec++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h64) begin
            n_err++;
            $display("FAIL alias_miss pt %b tgt %h want 0 64",
                     pred_taken, pred_target);
        end
        update_valid = 1'b1;
        update_pc = 32'h60;
        update_taken = 1'b1;
        update_target = 32'h300;
        #1;
        n_vec++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h64) begin
            n_err++;
            $display("FAIL rbw_old pt %b tgt %h want 0 64",
                     pred_taken, pred_target);
        end
        step();
        update_valid = 1'b0;
        n_vec++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin
            n_err++;
            $display("FAIL rbw_new pt %b tgt %h want 1 300",
                     pred_taken, pred_target);
        end
        pc_write = 1'b1;
        step();
        pc_write = 1'b0;
        n_vec++;
        if (current_pc !== 32'h300) begin
            n_err++;
            $display("FAIL alias_follow got %h want %h", current_pc, 32'h300);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h20;
        step();
        redirect_valid = 1'b0;
        n_vec++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h24) begin
            n_err++;
            $display("FAIL alias_evict pt %b tgt %h want 0 24",
                     pred_taken, pred_target);
        end
    endtask

    task automatic test_reset_trained();
        is_not_cache_stall = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h500;
        reset = 1'b1;
        step();
        reset = 1'b0;
        redirect_valid = 1'b0;
        is_not_cache_stall = 1'b1;
        n_vec++;
        if (current_pc !== 32'h0) begin
            n_err++;
            $display("FAIL rst_mid got %h want %h", current_pc, 32'h0);
        end
        redirect_valid = 1'b1;
        redirect_pc = 32'h60;
        step();
        redirect_valid = 1'b0;
        n_vec++;
        if (pred_taken !== 1'b0 || pred_target !== 32'h64) begin
            n_err++;
            $display("FAIL rst_clear pt %b tgt %h want 0 64",
                     pred_taken, pred_target);
        end
        // A stale valid entry would absorb the not-taken update and stay weak.
        update_valid = 1'b1;
        update_pc = 32'h60;
        update_taken = 1'b0;
        step();
        update_taken = 1'b1;
        update_target = 32'h300;
        step();
        update_valid = 1'b0;
        n_vec++;
        if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin
            n_err++;
            $display("FAIL rst_realloc pt %b tgt %h want 1 300",
                     pred_taken, pred_target);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_train();
        test_redirect();
        test_alias();
        test_reset_trained();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
